// File: rtl/fft_reader.sv
// fft_reader: read-side sequencer for the FFT result register file.
// On start it walks every bin address, samples the combinational real/imag
// read data and streams it out over a valid/ready handshake, marking the last
// bin and pulsing done when that bin is accepted downstream.
// Optional build macro BITREV_EN: read the register file in bit-reversed
// address order so decimation-ordered results come out in natural bin order.
module fft_reader #(
  parameter int NPOINT = 256,
  parameter int AW     = 8,
  parameter int DW     = 40
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] fft_addr,
  output logic          fft_wren,
  input  logic [DW-1:0] rd_datr,
  input  logic [DW-1:0] rd_dati,
  output logic [DW-1:0] out_r,
  output logic [DW-1:0] out_i,
  output logic [AW-1:0] out_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // cnt is one bit wider than the address so CNT_END means "no bins pending"
  localparam logic [AW:0]   CNT_END  = (AW+1)'(NPOINT);
  localparam logic [AW-1:0] LAST_IDX = AW'(NPOINT - 1);

  // Bin counter to register-file address
  function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] c);
    logic [AW-1:0] r;
`ifdef BITREV_EN
    for (int b = 0; b < AW; b++) begin
      r[b] = c[AW-1-b];
    end
`else
    r = c;
`endif
    return r;
  endfunction

  state_t        state_r, state_n;
  logic [AW:0]   cnt_r, cnt_n;
  logic          busy_r, busy_n;
  logic          done_r, done_n;
  logic [DW-1:0] out_r_r, out_r_n;
  logic [DW-1:0] out_i_r, out_i_n;
  logic [AW-1:0] out_idx_r, out_idx_n;
  logic          out_valid_r, out_valid_n;
  logic          out_last_r, out_last_n;
  logic          cnt_pending_s;
  logic          load_s;
  logic          accept_s;

  // Handshake qualifiers shared by the next-state logic
  always_comb begin
    cnt_pending_s = (cnt_r != CNT_END);
    accept_s      = out_valid_r & out_ready;
    load_s        = cnt_pending_s & (~out_valid_r | out_ready);
  end

  // Next-state and next-output logic; abort outranks frame end and load
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    busy_n      = busy_r;
    done_n      = 1'b0;
    out_r_n     = out_r_r;
    out_i_n     = out_i_r;
    out_idx_n   = out_idx_r;
    out_valid_n = out_valid_r;
    out_last_n  = out_last_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          cnt_n   = {(AW+1){1'b0}};
          busy_n  = 1'b1;
        end else begin
          busy_n = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_n     = IDLE;
          cnt_n       = {(AW+1){1'b0}};
          busy_n      = 1'b0;
          out_valid_n = 1'b0;
        end else if (accept_s && out_last_r) begin
          state_n     = IDLE;
          cnt_n       = {(AW+1){1'b0}};
          busy_n      = 1'b0;
          out_valid_n = 1'b0;
          done_n      = 1'b1;
        end else if (load_s) begin
          out_r_n     = rd_datr;
          out_i_n     = rd_dati;
          out_idx_n   = cnt_r[AW-1:0];
          out_last_n  = (cnt_r[AW-1:0] == LAST_IDX);
          out_valid_n = 1'b1;
          cnt_n       = cnt_r + (AW+1)'(1);
        end else if (accept_s) begin
          out_valid_n = 1'b0;
        end else begin
          out_valid_n = out_valid_r;
        end
      end
      default: begin
        state_n     = IDLE;
        cnt_n       = {(AW+1){1'b0}};
        busy_n      = 1'b0;
        out_valid_n = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= {(AW+1){1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      out_r_r     <= {DW{1'b0}};
      out_i_r     <= {DW{1'b0}};
      out_idx_r   <= {AW{1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      busy_r      <= busy_n;
      done_r      <= done_n;
      out_r_r     <= out_r_n;
      out_i_r     <= out_i_n;
      out_idx_r   <= out_idx_n;
      out_valid_r <= out_valid_n;
      out_last_r  <= out_last_n;
    end
  end

  // Read address follows the bin counter while a frame runs, parks at 0 otherwise
  always_comb begin
    if (state_r == RUN) begin
      fft_addr = map_addr(cnt_r[AW-1:0]);
    end else begin
      fft_addr = {AW{1'b0}};
    end
  end

  assign fft_wren  = 1'b0;
  assign busy      = busy_r;
  assign done      = done_r;
  assign out_r     = out_r_r;
  assign out_i     = out_i_r;
  assign out_idx   = out_idx_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;

endmodule
